// File: rtl/wb_queue.sv
// Writeback queue: buffers completed results and drains one per cycle onto the
// register file write port 1, pc update and cspr update ports, exporting a pending mask.
module wb_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_address,
  input  logic [N-1:0]             in_data,
  input  logic                     in_cspr_en,
  input  logic [N-1:0]             in_cspr,
  input  logic                     drain_hold,
  input  logic                     flush,
  output logic [3:0]               write_address,
  output logic [N-1:0]             write_data,
  output logic                     write_enable,
  output logic [N-1:0]             pc_update,
  output logic                     pc_write,
  output logic [N-1:0]             cspr_update,
  output logic                     cspr_write,
  output logic [15:0]              busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0]    addr_mem_r    [DEPTH];
  logic [N-1:0]  data_mem_r    [DEPTH];
  logic          cspr_en_mem_r [DEPTH];
  logic [N-1:0]  cspr_mem_r    [DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;
  logic [15:0]   busy_s;

  assign in_ready = (count_r < DEPTH_C) && !flush;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (count_r != {CW{1'b0}}) && !drain_hold && !flush;
  assign count    = count_r;
  assign busy     = busy_s;

  // Entry storage; contents outside the valid window are never observed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r]    <= in_address;
      data_mem_r[wr_ptr_r]    <= in_data;
      cspr_en_mem_r[wr_ptr_r] <= in_cspr_en;
      cspr_mem_r[wr_ptr_r]    <= in_cspr;
    end
  end

  // Pointers, occupancy and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      write_address <= 4'd0;
      write_data    <= {N{1'b0}};
      write_enable  <= 1'b0;
      pc_update     <= {N{1'b0}};
      pc_write      <= 1'b0;
      cspr_update   <= {N{1'b0}};
      cspr_write    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (flush) begin
        // A flush never coincides with an accepted push, so wr_ptr_r is stable here.
        count_r      <= {CW{1'b0}};
        rd_ptr_r     <= wr_ptr_r;
        write_enable <= 1'b0;
        pc_write     <= 1'b0;
        cspr_write   <= 1'b0;
      end else begin
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
        if (pop_s) begin
          rd_ptr_r   <= rd_ptr_r + PW'(1);
          cspr_write <= cspr_en_mem_r[rd_ptr_r];
          if (cspr_en_mem_r[rd_ptr_r]) begin
            cspr_update <= cspr_mem_r[rd_ptr_r];
          end
          if (addr_mem_r[rd_ptr_r] == 4'd15) begin
            pc_write     <= 1'b1;
            pc_update    <= data_mem_r[rd_ptr_r];
            write_enable <= 1'b0;
          end else begin
            pc_write      <= 1'b0;
            write_enable  <= 1'b1;
            write_address <= addr_mem_r[rd_ptr_r];
            write_data    <= data_mem_r[rd_ptr_r];
          end
        end else begin
          write_enable <= 1'b0;
          pc_write     <= 1'b0;
          cspr_write   <= 1'b0;
        end
      end
    end
  end

  // Pending mask: queued entries plus the entry the register file commits this cycle.
  always_comb begin
    busy_s = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = rd_ptr_r + PW'(i);
      if (CW'(i) < count_r) begin
        busy_s = busy_s | (16'd1 << addr_mem_r[idx]);
      end else begin
        busy_s = busy_s;
      end
    end
    if (write_enable) begin
      busy_s = busy_s | (16'd1 << write_address);
    end else begin
      busy_s = busy_s;
    end
    if (pc_write) begin
      busy_s[15] = 1'b1;
    end else begin
      busy_s = busy_s;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a vector table for single-entry flows plus
// hand-written sequences for backpressure/wrap, flush and mid-stream reset.
module tb_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_address;
  logic [31:0] in_data;
  logic        in_cspr_en;
  logic [31:0] in_cspr;
  logic        drain_hold;
  logic        flush;
  logic [3:0]  write_address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] pc_update;
  logic        pc_write;
  logic [31:0] cspr_update;
  logic        cspr_write;
  logic [15:0] busy;
  logic [2:0]  count;

  int total;
  int bad;

  wb_queue #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_address(in_address),
    .in_data(in_data), .in_cspr_en(in_cspr_en), .in_cspr(in_cspr),
    .drain_hold(drain_hold), .flush(flush),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
    .pc_update(pc_update), .pc_write(pc_write),
    .cspr_update(cspr_update), .cspr_write(cspr_write),
    .busy(busy), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [31:0] d;
    logic        ce;
    logic [31:0] c;
    logic        rdy;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pw;
    logic [31:0] pc;
    logic        cw;
    logic [31:0] cu;
    logic [15:0] bsy;
    logic [2:0]  cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] a, input logic [31:0] d,
                              input logic ce, input logic [31:0] c, input logic rdy,
                              input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic pw, input logic [31:0] pc, input logic cw,
                              input logic [31:0] cu, input logic [15:0] bsy, input logic [2:0] cnt);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.ce = ce; r.c = c; r.rdy = rdy;
    r.we = we; r.wa = wa; r.wd = wd; r.pw = pw; r.pc = pc;
    r.cw = cw; r.cu = cu; r.bsy = bsy; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                       input logic ce, input logic [31:0] c, input logic h, input logic f);
    in_valid = v; in_address = a; in_data = d; in_cspr_en = ce; in_cspr = c;
    drain_hold = h; flush = f;
  endtask

  vec_t tbl [14];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    tbl[0]  = mk(1'b1, 4'd3,  32'h0000_00A5, 1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,         16'h0008, 3'd1);
    tbl[1]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 4'd3, 32'hA5, 1'b0, 32'h0,   1'b0, 32'h0,         16'h0008, 3'd0);
    tbl[2]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 4'd3, 32'hA5, 1'b0, 32'h0,   1'b0, 32'h0,         16'h0000, 3'd0);
    tbl[3]  = mk(1'b1, 4'd15, 32'h0000_0100, 1'b1, 32'h6000_0000, 1'b1, 1'b0, 4'd3, 32'hA5, 1'b0, 32'h0,   1'b0, 32'h0,         16'h8000, 3'd1);
    tbl[4]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 4'd3, 32'hA5, 1'b1, 32'h100, 1'b1, 32'h6000_0000, 16'h8000, 3'd0);
    tbl[5]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 4'd3, 32'hA5, 1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0000, 3'd0);
    tbl[6]  = mk(1'b1, 4'd2,  32'h1,         1'b0, 32'h0,         1'b1, 1'b0, 4'd3, 32'hA5, 1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0004, 3'd1);
    tbl[7]  = mk(1'b1, 4'd2,  32'h2,         1'b0, 32'h0,         1'b1, 1'b1, 4'd2, 32'h1,  1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0004, 3'd1);
    tbl[8]  = mk(1'b1, 4'd2,  32'h3,         1'b0, 32'h0,         1'b1, 1'b1, 4'd2, 32'h2,  1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0004, 3'd1);
    tbl[9]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 4'd2, 32'h3,  1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0004, 3'd0);
    tbl[10] = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 4'd2, 32'h3,  1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0000, 3'd0);
    tbl[11] = mk(1'b1, 4'd5,  32'h55,        1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'd2, 32'h3,  1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0020, 3'd1);
    tbl[12] = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 4'd5, 32'h55, 1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0020, 3'd0);
    tbl[13] = mk(1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 4'd5, 32'h55, 1'b0, 32'h100, 1'b0, 32'h6000_0000, 16'h0000, 3'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_we",    {31'd0, write_enable}, 32'd0);
    chk("reset_pw",    {31'd0, pc_write},     32'd0);
    chk("reset_cw",    {31'd0, cspr_write},   32'd0);
    chk("reset_wd",    write_data,            32'd0);
    chk("reset_busy",  {16'd0, busy},         32'd0);
    chk("reset_count", {29'd0, count},        32'd0);
    chk("reset_ready", {31'd0, in_ready},     32'd1);

    // Table: single write, pc/cspr update, same-destination ordering, cspr hold.
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      drive(tbl[v].v, tbl[v].a, tbl[v].d, tbl[v].ce, tbl[v].c, 1'b0, 1'b0);
      #1;
      chk($sformatf("v%0d_ready", v), {31'd0, in_ready}, {31'd0, tbl[v].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", v),    {31'd0, write_enable},  {31'd0, tbl[v].we});
      chk($sformatf("v%0d_wa", v),    {28'd0, write_address}, {28'd0, tbl[v].wa});
      chk($sformatf("v%0d_wd", v),    write_data,             tbl[v].wd);
      chk($sformatf("v%0d_pw", v),    {31'd0, pc_write},      {31'd0, tbl[v].pw});
      chk($sformatf("v%0d_pc", v),    pc_update,              tbl[v].pc);
      chk($sformatf("v%0d_cw", v),    {31'd0, cspr_write},    {31'd0, tbl[v].cw});
      chk($sformatf("v%0d_cu", v),    cspr_update,            tbl[v].cu);
      chk($sformatf("v%0d_busy", v),  {16'd0, busy},          {16'd0, tbl[v].bsy});
      chk($sformatf("v%0d_count", v), {29'd0, count},         {29'd0, tbl[v].cnt});
    end

    // Backpressure: hold drain and offer R1..R5; only four fit.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 4'(i + 1), 32'h11 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
      #1;
      chk($sformatf("full_ready%0d", i), {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_busy",  {16'd0, busy},  32'h0000_001E);
    chk("full_we",    {31'd0, write_enable}, 32'd0);

    // Release and keep offering R5..R10; drain order must be R1..R10 across wrap.
    begin
      int k;
      k = 4;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (k < 10) drive(1'b1, 4'(k + 1), 32'h11 + 32'(k), 1'b0, 32'd0, 1'b0, 1'b0);
        else        drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        if (k < 10) begin
          chk($sformatf("wrap_ready%0d", j), {31'd0, in_ready}, (j == 0) ? 32'd0 : 32'd1);
          if (j != 0) k++;
        end
        @(posedge clk);
        #1;
        chk($sformatf("wrap_we%0d", j),    {31'd0, write_enable},  32'd1);
        chk($sformatf("wrap_wa%0d", j),    {28'd0, write_address}, 32'(j + 1));
        chk($sformatf("wrap_wd%0d", j),    write_data,             32'h11 + 32'(j));
        chk($sformatf("wrap_count%0d", j), {29'd0, count},         (j <= 6) ? 32'd3 : 32'(9 - j));
      end
    end

    // Flush with three entries queued and a push offered in the same cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 4'(i + 7), 32'h77 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("preflush_count", {29'd0, count}, 32'd3);
    chk("preflush_busy",  {16'd0, busy},  32'h0000_0380);
    @(negedge clk);
    drive(1'b1, 4'd12, 32'hCC, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("flush_we",    {31'd0, write_enable}, 32'd0);
    chk("flush_cw",    {31'd0, cspr_write},   32'd0);
    chk("flush_count", {29'd0, count},        32'd0);
    chk("flush_busy",  {16'd0, busy},         32'd0);
    @(negedge clk);
    drive(1'b1, 4'd6, 32'h66, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("postflush_we",    {31'd0, write_enable}, 32'd0);
    chk("postflush_count", {29'd0, count},        32'd1);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("postflush_wa", {28'd0, write_address}, 32'd6);
    chk("postflush_wd", write_data,             32'h66);
    chk("postflush_cw", {31'd0, cspr_write},    32'd0);

    // Reset mid-stream: three entries queued behind a drain hold.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 4'(i + 1), 32'hA0 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("prerst_busy", {16'd0, busy}, 32'h0000_000E);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  {16'd0, busy},          32'd0);
    chk("rst_count", {29'd0, count},         32'd0);
    chk("rst_wa",    {28'd0, write_address}, 32'd0);
    chk("rst_wd",    write_data,             32'd0);
    chk("rst_pc",    pc_update,              32'd0);
    chk("rst_cu",    cspr_update,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drain_hold = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_no_pop", {31'd0, write_enable}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback queue between the execute/memory units and the synchronous register file.
- Buffers completed results and drains one per cycle onto the register file's write port 1, its pc update port and its cspr update port.
- Outputs change on posedge clk; the register file samples them on the following negedge.
- Also exports a per-register pending mask so decode can stall on read-after-write hazards, including the entry being committed in the current cycle. The register file reads before it writes at the same negedge, so that entry must still count as pending.

Parameters:
- N, 32, data width of results, pc and cspr.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  result presented by upstream.
- in_ready  output  1  queue can accept; transfer occurs when in_valid and in_ready are both 1 at posedge.
- in_address  input  4  destination register; 15 means pc.
- in_data  input  N  result value.
- in_cspr_en  input  1  entry also updates cspr.
- in_cspr  input  N  new cspr value.
- drain_hold  input  1  when 1, no entry is popped this cycle.
- flush  input  1  synchronous discard of all queued entries.
- write_address  output  4  to register file write_address_1.
- write_data  output  N  to register file write_data_1.
- write_enable  output  1  to register file write_enable_1.
- pc_update  output  N  to register file pc_update.
- pc_write  output  1  to register file pc_write.
- cspr_update  output  N  to register file cspr_update.
- cspr_write  output  1  to register file cspr_write.
- busy  output  16  bit r = 1 while any queued or issuing entry targets register r.
- count  output  clog2(DEPTH)+1  number of valid FIFO entries, excluding the output stage.

Behaviour:
- Reset (rst_n = 0, asynchronous): wr/rd pointers 0, count 0, all strobes 0, write_address 0, write_data 0, pc_update 0, cspr_update 0, busy 0. Entries in flight are lost.
- FIFO: circular, with separate pointers that wrap modulo DEPTH.
- in_ready = (count < DEPTH) and not flush. It is combinational from registered count and the flush input only.
- Push: at posedge, when in_valid and in_ready, write {in_address, in_data, in_cspr_en, in_cspr} at wr_ptr and advance wr_ptr.
- Pop: at posedge, when count > 0 and not drain_hold and not flush, load the head into the output stage and advance rd_ptr.
  - If address != 15: write_enable = 1, write_address/write_data = entry.
  - If address == 15: pc_write = 1, pc_update = data, write_enable = 0.
  - cspr_write = entry cspr_en; cspr_update = entry cspr when cspr_en = 1, otherwise it holds its previous value.
- Strobes (write_enable, pc_write, cspr_write) are 1 for exactly one cycle per popped entry, and 0 on any cycle without a pop.
- Data and address outputs hold their last value when idle.
- Latency: an entry pushed at edge k is popped at edge k+1 at the earliest (empty queue, no hold). The register file commits it at the negedge inside cycle k+1. There is no bypass from input to output.
- Simultaneous push and pop: count unchanged. When full (count = DEPTH), in_ready = 0 even if a pop happens in the same cycle.
- Ordering: strict FIFO; two entries to the same register commit in arrival order.
- busy: OR over valid FIFO entries of onehot(address), OR'd with onehot(write_address) while write_enable = 1, and with bit 15 while pc_write = 1. It is combinational from registered state.
- Flush: at posedge, count := 0, rd_ptr := wr_ptr, and all strobes cleared.
  - A push in the same cycle is refused (in_ready = 0).
  - Flush takes priority over pop; busy reads 0 on the following cycle.
- drain_hold with flush: flush wins.
- count is never negative and never above DEPTH. Push is only accepted via in_ready; pop is only taken when count > 0.

Test Plan:
- Reset mid-stream: push 3 entries, hold drain, assert rst_n = 0 between edges -> outputs and busy go to 0 immediately, count = 0, in_ready = 1 after release.
- Single write: push R3 = 0x0000_00A5, cspr_en = 0 -> next cycle write_enable = 1, write_address = 3, write_data = 0xA5 for one cycle; busy[3] = 1 for 2 cycles, then 0. Register file R3 reads 0xA5 afterwards.
- pc and cspr: push R15 = 0x0000_0100 with cspr_en = 1, in_cspr = 0x6000_0000 -> pc_write = 1, pc_update = 0x100, cspr_write = 1, cspr_update = 0x6000_0000, write_enable = 0.
- Full/backpressure, DEPTH = 4: hold drain, push 5 back-to-back -> 4 accepted, count = 4, in_ready = 0 on the 5th. Release hold -> pops one per cycle in order, in_ready returns to 1 after the first pop edge. Wrap: push 6 more across release; order is preserved.
- Same-destination ordering: push R2 = 1, R2 = 2, R2 = 3 -> three consecutive writes in order 1, 2, 3; busy[2] stays 1 until the cycle after the last write.
- Flush: queue holds 3 entries; assert flush with in_valid = 1 -> no pop strobes, count = 0, in_ready = 0 during flush, busy = 0 next cycle, and the presented entry is not stored.
